// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: aluc codes, FSM state,
// serial-shift kinds and small decode helpers.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1000;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shift_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Only meaningful when is_shift(op) is true.
    function automatic shift_t shift_kind(input logic [3:0] op);
        case (op)
            ALU_SRL: return SH_RL;
            ALU_SRA: return SH_RA;
            default: return SH_LL;
        endcase
    endfunction

endpackage

// File: rtl/alu_exec_comb.sv
// Single-cycle ALU datapath: logic, add/sub with signed overflow, slt.
// Shift codes pass b through; the multi-bit shift is done serially
// in alu_exec, and b is exactly the result of a zero-length shift.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             lt;

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
    // Differing signs decide the compare directly, so the wrapped
    // difference is only consulted when it cannot have overflowed.
    assign lt      = (a[MSB] != b[MSB]) ? a[MSB] : diff[MSB];

    // Opcode select; unknown codes behave as add.
    always_comb begin
        value = sum;
        ovf   = add_ovf;
        case (aluc)
            ALU_AND: begin
                value = a & b;
                ovf   = 1'b0;
            end
            ALU_OR: begin
                value = a | b;
                ovf   = 1'b0;
            end
            ALU_SUB: begin
                value = diff;
                ovf   = sub_ovf;
            end
            ALU_SLT: begin
                value = {{(WIDTH-1){1'b0}}, lt};
                ovf   = 1'b0;
            end
            ALU_NOR: begin
                value = ~(a | b);
                ovf   = 1'b0;
            end
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                value = b;
                ovf   = 1'b0;
            end
            default: begin
                value = sum;
                ovf   = add_ovf;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with one-cycle logic/arithmetic ops and a serial
// one-bit-per-cycle shifter. in_ready stalls the front end during shifts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready; accepts one op per cycle, single-cycle ops finish here
// S_SHIFT | sreg shifts one bit per edge until cnt reaches 1 or flush
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    state_t           state;
    shift_t           sh_kind;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_step;
    logic [WIDTH-1:0] comb_value;
    logic             comb_ovf;
    logic             accept;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready & ~flush;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .aluc  (aluc),
        .a     (a),
        .b     (b),
        .value (comb_value),
        .ovf   (comb_ovf)
    );

    // One-bit step of the serial shifter for the latched shift kind.
    always_comb begin
        sreg_step = sreg;
        case (sh_kind)
            SH_LL:   sreg_step = {sreg[WIDTH-2:0], 1'b0};
            SH_RL:   sreg_step = {1'b0, sreg[WIDTH-1:1]};
            SH_RA:   sreg_step = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
            default: sreg_step = sreg;
        endcase
    end

    // Control FSM, shift counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sh_kind   <= SH_LL;
            cnt       <= '0;
            sreg      <= '0;
            result    <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!is_shift(aluc)) begin
                            result    <= comb_value;
                            zero      <= (comb_value == '0);
                            overflow  <= comb_ovf;
                            out_valid <= 1'b1;
                        end else if (shamt == '0) begin
                            result    <= b;
                            zero      <= (b == '0);
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            sreg    <= b;
                            cnt     <= shamt;
                            sh_kind <= shift_kind(aluc);
                            state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    // Flush beats completion: result keeps its old value.
                    if (flush) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        sreg <= sreg_step;
                        cnt  <= cnt - SHW'(1);
                        if (cnt == SHW'(1)) begin
                            result    <= sreg_step;
                            zero      <= (sreg_step == '0);
                            overflow  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases plus randomized
// ops compared against an arithmetic reference model.
module tb_alu_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        flush;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int checks;
    int failures;

    alu_exec #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluc      (aluc),
        .a         (a),
        .b         (b),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results straight from the opcode definitions using
    // wide signed arithmetic; latency is 1 + shift distance.
    function automatic void model(input logic [3:0] op, input logic [31:0] oa,
                                  input logic [31:0] ob, input logic [4:0] sh,
                                  output logic [31:0] res, output logic ovf,
                                  output int lat);
        longint sa;
        longint sb;
        longint full;
        sa   = longint'($signed(oa));
        sb   = longint'($signed(ob));
        full = 0;
        ovf  = 1'b0;
        lat  = 1;
        case (op)
            4'h0: res = oa & ob;
            4'h1: res = oa | ob;
            4'h6: full = sa - sb;
            4'h7: res = (sa < sb) ? 32'd1 : 32'd0;
            4'h8: res = ~(oa | ob);
            4'h3: begin res = ob << sh;  lat = int'(sh) + 1; end
            4'h4: begin res = ob >> sh;  lat = int'(sh) + 1; end
            4'h5: begin res = $unsigned($signed(ob) >>> sh); lat = int'(sh) + 1; end
            default: full = sa + sb;
        endcase
        if (op == 4'h6 || !(op <= 4'h1 || (op >= 4'h3 && op <= 4'h5) || op == 4'h7 || op == 4'h8)) begin
            res = full[31:0];
            ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
        end
    endfunction

    // Offer one op from IDLE, wait (bounded) for its out_valid while
    // driving ignored garbage, then check timing, outputs and pulse width.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] oa,
                         input logic [31:0] ob, input logic [4:0] sh,
                         input logic [31:0] e_res, input logic e_ovf, input int e_lat);
        int n;
        int low;
        chk({tag, "/ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        aluc     = op;
        a        = oa;
        b        = ob;
        shamt    = sh;
        tick();
        in_valid = 1'b0;
        n   = 1;
        low = 0;
        while (!out_valid && n < 64) begin
            if (!in_ready) low++;
            in_valid = 1'($urandom_range(0, 1));
            aluc     = 4'($urandom);
            a        = $urandom;
            b        = $urandom;
            shamt    = 5'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "/latency"}, 32'(n), 32'(e_lat));
        chk({tag, "/busy"}, 32'(low), 32'(e_lat - 1));
        chk({tag, "/result"}, result, e_res);
        chk({tag, "/zero"}, 32'(zero), 32'(e_res == 32'd0));
        chk({tag, "/ovf"}, 32'(overflow), 32'(e_ovf));
        tick();
        chk({tag, "/pulse"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] e_res;
        logic        e_ovf;
        int          e_lat;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rsh;
        logic [31:0] corners [4];
        int          stray;

        checks    = 0;
        failures  = 0;
        corners[0] = 32'h7FFF_FFFF;
        corners[1] = 32'h8000_0000;
        corners[2] = 32'h0000_0000;
        corners[3] = 32'hFFFF_FFFF;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        aluc     = 4'h0;
        a        = '0;
        b        = '0;
        shamt    = '0;
        flush    = 1'b0;
        repeat (3) tick();
        chk("reset/result", result, 32'd0);
        chk("reset/zero", 32'(zero), 32'd1);
        chk("reset/ovf", 32'(overflow), 32'd0);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back single-cycle ops give consecutive out_valid pulses.
        in_valid = 1'b1; aluc = 4'b0010; a = 32'h7FFF_FFFF; b = 32'd1;
        tick();
        chk("b2b/v0", 32'(out_valid), 32'd1);
        chk("b2b/r0", result, 32'h8000_0000);
        chk("b2b/o0", 32'(overflow), 32'd1);
        aluc = 4'b0110; a = 32'd5; b = 32'd7;
        tick();
        chk("b2b/v1", 32'(out_valid), 32'd1);
        chk("b2b/r1", result, 32'hFFFF_FFFE);
        chk("b2b/o1", 32'(overflow), 32'd0);
        aluc = 4'b0111; a = 32'hFFFF_FFFF; b = 32'd1;
        tick();
        chk("b2b/v2", 32'(out_valid), 32'd1);
        chk("b2b/r2", result, 32'd1);
        chk("b2b/o2", 32'(overflow), 32'd0);
        chk("b2b/rdy", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("b2b/end", 32'(out_valid), 32'd0);

        do_op("sra4", 4'b0101, 32'd0, 32'h8000_0010, 5'd4, 32'hF800_0001, 1'b0, 5);
        do_op("sll0", 4'b0011, 32'd0, 32'h0000_1234, 5'd0, 32'h0000_1234, 1'b0, 1);
        do_op("undef", 4'b1111, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1);
        do_op("nor0", 4'b1000, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b0, 1);
        do_op("slt_ovf", 4'b0111, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'd1, 1'b0, 1);

        // Flush at the tenth edge of a long srl: nothing completes.
        do_op("pre_flush", 4'b0000, 32'hFFFF_ABCD, 32'h0000_FFFF, 5'd0, 32'h0000_ABCD, 1'b0, 1);
        in_valid = 1'b1; aluc = 4'b0100; a = 32'd0; b = 32'hFFFF_FFFF; shamt = 5'd31;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush/in_ready", 32'(in_ready), 32'd1);
        chk("flush/out_valid", 32'(out_valid), 32'd0);
        chk("flush/result", result, 32'h0000_ABCD);
        stray = 0;
        repeat (40) begin
            tick();
            if (out_valid) stray++;
        end
        chk("flush/stray", 32'(stray), 32'd0);
        do_op("post_flush", 4'b0001, 32'h0F00_0000, 32'h0000_00F0, 5'd0, 32'h0F00_00F0, 1'b0, 1);

        // Flush on the completing edge wins.
        in_valid = 1'b1; aluc = 4'b0011; b = 32'h1; shamt = 5'd3;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_last/out_valid", 32'(out_valid), 32'd0);
        chk("flush_last/result", result, 32'h0F00_00F0);
        chk("flush_last/in_ready", 32'(in_ready), 32'd1);

        // Flush in IDLE blocks acceptance.
        in_valid = 1'b1; flush = 1'b1; aluc = 4'b0010; a = 32'd1; b = 32'd1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle/out_valid", 32'(out_valid), 32'd0);
        chk("flush_idle/result", result, 32'h0F00_00F0);
        tick();
        chk("flush_idle/late", 32'(out_valid), 32'd0);

        // Reset asserted mid-shift aborts at once.
        in_valid = 1'b1; aluc = 4'b0011; b = 32'h3; shamt = 5'd20;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst/result", result, 32'd0);
        chk("midrst/zero", 32'(zero), 32'd1);
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/in_ready", 32'(in_ready), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (25) begin
            tick();
            if (out_valid) stray++;
        end
        chk("midrst/stray", 32'(stray), 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            op  = 4'($urandom_range(0, 15));
            ra  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
            rsh = 5'($urandom_range(0, 31));
            model(op, ra, rb, rsh, e_res, e_ovf, e_lat);
            do_op($sformatf("rand%0d_op%0h", i, op), op, ra, rb, rsh, e_res, e_ovf, e_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the pipelined MIPS core. It consumes the 4-bit `aluc` operation code produced by the ALU-control decoder, together with the operands from ID/EX. Logic and arithmetic operations complete in one cycle. Shifts run on a serial one-bit-per-cycle shifter, so the block exposes `in_ready`, which the hazard unit uses to stall the front end while a shift is in flight.

## Interface
- `WIDTH`, 32, datapath width
- `SHW`, 5, shift-amount width; must equal log2(`WIDTH`)

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous reset, active-low
- `in_valid`  in  1  ID/EX presents an operation this cycle
- `in_ready`  out  1  block can accept an operation (state IDLE)
- `aluc`  in  4  operation code
- `a`  in  WIDTH  operand rs
- `b`  in  WIDTH  operand rt or immediate
- `shamt`  in  SHW  shift amount (shift ops only)
- `flush`  in  1  kill any in-flight or offered operation
- `out_valid`  out  1  one-cycle pulse; `result`, `zero` and `overflow` are valid
- `result`  out  WIDTH  registered result
- `zero`  out  1  `result` == 0
- `overflow`  out  1  signed overflow (add/sub only)

## Operation
**Opcode decode (`aluc`)**
- 0000: a & b
- 0001: a | b
- 0010: a + b
- 0110: a − b
- 0111: slt (signed a < b gives 1, else 0)
- 1000: ~(a | b)
- 0011: sll b by `shamt`
- 0100: srl b by `shamt`
- 0101: sra b by `shamt`
- Any other code executes as add (0010).

**Accept rule**
- An operation is accepted when `in_valid & in_ready & ~flush` at a rising edge.
- Operands are sampled only on accept.

**State machine (IDLE, SHIFT)**
- IDLE, non-shift op accepted: `result` is loaded with the combinational value and `out_valid` is set. State stays IDLE.
- IDLE, shift op with `shamt`==0 accepted: `result` = b and `out_valid` is set. State stays IDLE.
- IDLE, shift op with `shamt`>0 accepted: load `sreg` = b, `cnt` = `shamt`, latch the op; go to SHIFT. `out_valid` = 0.
- SHIFT, each edge: `sreg` shifts by one bit (sll: zero in at LSB; srl: zero in at MSB; sra: MSB replicated) and `cnt` decrements.
  - The edge where `cnt`==1 writes the shifted value to `result`, sets `out_valid`, and returns to IDLE.
- `in_ready` = (state == IDLE); it is combinational from state only.

**Flush and output rules**
- `flush` in SHIFT returns to IDLE at the next edge with `out_valid` = 0 and `result` unchanged.
- `flush` in IDLE blocks acceptance.
- `out_valid` is high for exactly one cycle per completed operation. There is no output backpressure.

**Arithmetic**
- Add and sub are modulo 2^WIDTH.
- add overflow = (a[msb]==b[msb]) & (sum[msb]!=a[msb]).
- sub overflow = (a[msb]!=b[msb]) & (diff[msb]!=a[msb]).
- slt uses a signed compare, correct even when a − b overflows.
- `zero` and `overflow` are registered together with `result`. `overflow` = 0 for all non-add/sub ops.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `cnt` = 0, `result` = 0, `zero` = 1, `overflow` = 0, `out_valid` = 0. `in_ready` reads 1.
- Latency from the accept edge:
  - Non-shift ops: `out_valid` in the next cycle (1 cycle).
  - Shifts: 1 + `shamt` cycles.
- Throughput: one non-shift op per cycle. Back-to-back accepts give back-to-back `out_valid`.
- During SHIFT, `in_valid` is ignored and `in_ready` = 0.
- A new op may be accepted on the same edge that completes a shift only if state was IDLE at that edge, which is never true. The next accept is therefore one cycle later.
- `flush` and the final shift edge (`cnt`==1) coincide: flush wins, and `out_valid` = 0.
- Reset asserted mid-shift aborts immediately to the reset values.

## Structure
- Package `alu_pkg`:
  - `aluc` localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_NOR)
  - 1-bit state enum (S_IDLE, S_SHIFT)
  - `is_shift` function
- Sub-module `alu_comb`: purely combinational single-cycle datapath (a, b, aluc gives value and ovf). Instantiated once; the FSM, counter, serial shifter and output registers stay in `alu_exec`.

## Test plan
- **Reset:** hold `rst_n` = 0 mid-run → `result` = 0, `zero` = 1, `out_valid` = 0, `in_ready` = 1.
- **Back-to-back ops:** add 0x7FFFFFFF + 1, then sub 5 − 7, then slt (−1, 1) on consecutive cycles → results 0x80000000 ovf = 1; 0xFFFFFFFE ovf = 0; 1. Three consecutive `out_valid` pulses.
- **sra:** `aluc` = 0101, b = 0x80000010, `shamt` = 4 → `in_ready` low for 4 cycles; `out_valid` 5 cycles after accept; `result` = 0xF8000001.
- **sll with shamt 0:** `aluc` = 0011, `shamt` = 0, b = 0x1234 → `result` 0x1234 after 1 cycle, no SHIFT state. Also `aluc` = 1111, a = 2, b = 3 → `result` 5.
- **Flush mid-shift:** srl b = 0xFFFFFFFF, `shamt` = 31, `flush` at cycle 10 → no `out_valid`, IDLE next cycle, prior `result` retained. A following op is accepted normally.
- **Zero flag:** nor a = 0xFFFFFFFF, b = 0 → `result` 0, `zero` = 1, `overflow` = 0.
